// File: rtl/shift_add_mul_ctrl.sv
// Sequential unsigned shift-and-add multiplier with Start/Busy/Done handshake.
// Optional early exit on exhausted multiplier bits: define SHIFT_ADD_MUL_EARLY_TERM_EN.
module shift_add_mul_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] R
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] p_q;
  logic [2*WIDTH-1:0] r_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   add_sum_s;
  logic               add_carry_s;
  logic [2*WIDTH-1:0] p_d;
  logic [2*WIDTH-1:0] r_d;
  logic               last_s;

  // Shared ripple-carry adder: upper half of P plus the multiplicand.
  always_comb begin
    add_carry_s = 1'b0;
    add_sum_s   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      add_sum_s[i] = p_q[WIDTH+i] ^ m_q[i] ^ add_carry_s;
      add_carry_s  = (p_q[WIDTH+i] & m_q[i]) | (add_carry_s & (p_q[WIDTH+i] ^ m_q[i]));
    end
  end

  // One iteration: conditional add, then shift right keeping the carry as new MSB.
  always_comb begin
    if (p_q[0]) begin
      p_d = {add_carry_s, add_sum_s, p_q[WIDTH-1:1]};
    end else begin
      p_d = {1'b0, p_q[2*WIDTH-1:1]};
    end
  end

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  logic [WIDTH-1:0] rem_mask_s;

  // Finish as soon as the unconsumed multiplier bits are all zero; realign P.
  always_comb begin
    rem_mask_s = {WIDTH{1'b1}} >> (count_q + CW'(1));
    last_s     = (count_q == CW'(WIDTH-1)) || ((p_d[WIDTH-1:0] & rem_mask_s) == '0);
    r_d        = p_d >> (CW'(WIDTH-1) - count_q);
  end
`else
  // Full-length run only.
  always_comb begin
    last_s = (count_q == CW'(WIDTH-1));
    r_d    = p_d;
  end
`endif

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            m_q     <= A;
            p_q     <= {{WIDTH{1'b0}}, B};
            count_q <= '0;
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
          done_q <= 1'b0;
        end
        S_RUN: begin
          p_q     <= p_d;
          count_q <= count_q + CW'(1);
          if (last_s) begin
            r_q     <= r_d;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign R    = r_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Randomized self-checking bench for shift_add_mul_ctrl against an arithmetic reference.
module tb_shift_add_mul_ctrl;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           Start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           Busy;
  logic           Done;
  logic [2*W-1:0] R;

  int n_checks  = 0;
  int n_fail    = 0;
  int n_done    = 0;
  int n_started = 0;
  logic [2*W-1:0] last_r = '0;

  shift_add_mul_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .R(R)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && Done) n_done++;

  function automatic int exp_len(input logic [W-1:0] b);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n;
`else
    return W;
`endif
  endfunction

  // Caller sits at a negedge in IDLE; returns at the negedge after the Done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble);
    logic [2*W-1:0] exp_r;
    int cyc;
    exp_r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    Start = 1'b1; A = a; B = b;
    n_started++;
    @(negedge clk);
    if (!scramble) Start = 1'b0;
    cyc = 0;
    while (Busy && cyc < 3*W) begin
      n_checks++;
      if (R !== last_r) begin
        n_fail++;
        $display("FAIL r_hold_in_run: got %h want %h", R, last_r);
      end
      if (scramble) begin A = $urandom; B = $urandom; end
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (cyc != exp_len(b)) begin
      n_fail++;
      $display("FAIL busy_len a=%h b=%h: got %0d want %0d", a, b, cyc, exp_len(b));
    end
    n_checks++;
    if (Done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_pulse: got %b want 1", Done);
    end
    n_checks++;
    if (R !== exp_r) begin
      n_fail++;
      $display("FAIL product a=%h b=%h: got %h want %h", a, b, R, exp_r);
    end
    last_r = exp_r;
    @(negedge clk);
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL back_to_idle: got done=%b busy=%b want 0 0", Done, Busy);
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || R !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b done=%b r=%h want 0 0 0", Busy, Done, R);
    end
    @(negedge clk);
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_start: got busy=%b want 0", Busy);
    end
  endtask

  task automatic test_directed();
    run_op(32'd3, 32'd5, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(32'h1234_5678, 32'd1, 1'b0);
    run_op(32'h1234_5678, 32'd0, 1'b0);
    run_op(32'd0, 32'hDEAD_BEEF, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
  endtask

  task automatic test_start_held();
    run_op(32'hCAFE_0001, 32'h9000_0003, 1'b1);
    run_op(32'h0000_00FF, 32'h0000_0101, 1'b1);
  endtask

  task automatic test_mid_run_reset();
    run_op(32'h0001_0001, 32'h0000_0777, 1'b0);
    Start = 1'b1; A = $urandom; B = 32'h8000_0001;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (Busy !== 1'b0 || R !== '0 || Done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got busy=%b done=%b r=%h want 0 0 0", Busy, Done, R);
    end
    @(negedge clk);
    rst = 1'b0;
    last_r = '0;
    n_done = 0; n_started = 0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_quiet: got done=%b busy=%b want 0 0", Done, Busy);
      end
    end
    run_op(32'd7, 32'd6, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = W'($urandom) >> $urandom_range(0, W);
      if ($urandom_range(0, 15) == 0) a = '0;
      run_op(a, b, 1'b0);
    end
    @(negedge clk);
    n_checks++;
    if (n_done != n_started) begin
      n_fail++;
      $display("FAIL done_count: got %0d want %0d", n_done, n_started);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_held();
    test_mid_run_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
